spi_ram_burst: RTL and testbench

Parametrised single-port RAM behind the SPI slave command interface. It is the next generation of the SPI-side RAM.
- Decodes the 2-bit command field on each rx_valid word into write-address, write-data, read-address and read-data operations.
- Adds an auto-increment burst mode, an optional output pipeline register and out-of-range address detection for non-power-of-two depths.
- Sits between the SPI slave shift/FSM block (source of din/rx_valid) and its MISO serialiser (consumer of dout/tx_valid).

---
 rtl/spi_ram_pkg.sv | 20 ++
 rtl/spi_ram_rd_pipe.sv | 59 +++++
 rtl/spi_ram_burst.sv | 101 ++++++++++
 tb/tb_spi_ram_burst.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command encodings and helpers for the SPI-side burst RAM.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  function automatic int unsigned max_width(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Out-of-range addresses also land on 0, so one compare covers both cases.
  function automatic int unsigned wrap_inc(int unsigned addr, int unsigned depth);
    return (addr + 1 >= depth) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/spi_ram_rd_pipe.sv
// Read-return delay line: one or two register stages carrying {valid, err, data}.
module spi_ram_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic                  in_err_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  s1_valid_q;
  logic                  s1_err_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  // Data only loads on a valid beat so dout holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= in_valid_i;
      s1_err_q   <= in_err_i;
      if (in_valid_i) s1_data_q <= in_data_i;
    end
  end

  if (OUT_REG == 0) begin : g_direct
    assign valid_o = s1_valid_q;
    assign err_o   = s1_err_q;
    assign data_o  = s1_data_q;
  end else begin : g_outreg
    logic                  s2_valid_q;
    logic                  s2_err_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign valid_o = s2_valid_q;
    assign err_o   = s2_err_q;
    assign data_o  = s2_data_q;
  end

endmodule

// File: rtl/spi_ram_burst.sv
// Single-port RAM behind the SPI slave: command decode, burst addressing, range check.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned OUT_REG    = 0,
  localparam int unsigned PW        = max_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [PW+1:0]         din,
  input  logic                  auto_inc,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  addr_err
);

  localparam logic [ADDR_WIDTH:0] DepthL = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_err_q, wr_err_d;
  logic                  mem_we;
  logic                  rd_valid;
  logic                  rd_err;
  logic                  wr_oor;
  logic                  rd_oor;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  pipe_err;
  cmd_e                  cmd;

  assign cmd    = cmd_e'(din[PW+1:PW]);
  assign wr_oor = {1'b0, wr_addr_q} >= DepthL;
  assign rd_oor = {1'b0, rd_addr_q} >= DepthL;

  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_err_d  = 1'b0;
    mem_we    = 1'b0;
    rd_valid  = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: wr_addr_d = din[ADDR_WIDTH-1:0];
        CMD_WR_DATA: begin
          mem_we   = !wr_oor;
          wr_err_d = wr_oor;
          if (auto_inc) wr_addr_d = ADDR_WIDTH'(wrap_inc(32'(wr_addr_q), MEM_DEPTH));
        end
        CMD_RD_ADDR: rd_addr_d = din[ADDR_WIDTH-1:0];
        CMD_RD_DATA: begin
          rd_valid = 1'b1;
          if (auto_inc) rd_addr_d = ADDR_WIDTH'(wrap_inc(32'(rd_addr_q), MEM_DEPTH));
        end
      endcase
    end
  end

  // Out-of-range reads return zero rather than whatever the array index aliases to.
  assign rd_data = rd_oor ? '0 : mem_q[rd_addr_q];
  assign rd_err  = rd_valid & rd_oor;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr_q] <= din[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_err_q  <= wr_err_d;
    end
  end

  spi_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rd_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (rd_valid),
    .in_err_i   (rd_err),
    .in_data_i  (rd_data),
    .valid_o    (tx_valid),
    .err_o      (pipe_err),
    .data_o     (dout)
  );

  // Write errors always surface one cycle after the write, independent of OUT_REG.
  assign addr_err = pipe_err | wr_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed and random checks of spi_ram_burst in three configurations.
module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] din;
  logic       auto_inc;

  logic [7:0] d0_dout, d1_dout, d2_dout;
  logic       d0_tx, d1_tx, d2_tx;
  logic       d0_err, d1_err, d2_err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_ram_burst u_d0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .auto_inc(auto_inc),
    .dout(d0_dout), .tx_valid(d0_tx), .addr_err(d0_err)
  );

  spi_ram_burst #(.MEM_DEPTH(200)) u_d1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .auto_inc(auto_inc),
    .dout(d1_dout), .tx_valid(d1_tx), .addr_err(d1_err)
  );

  spi_ram_burst #(.OUT_REG(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .auto_inc(auto_inc),
    .dout(d2_dout), .tx_valid(d2_tx), .addr_err(d2_err)
  );

  // Reference model, one slot per DUT.
  int unsigned depth [3] = '{256, 200, 256};
  int unsigned lat   [3] = '{1, 1, 2};
  logic [7:0] m_mem [3][256];
  logic [7:0] m_wa [3], m_ra [3];
  logic       s1_v [3], s1_e [3], o_v [3], o_e [3];
  logic [7:0] s1_d [3], o_d [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_inc(input logic [7:0] a, input int unsigned dep);
    return (int'(a) + 1 >= dep) ? 8'h00 : a + 8'h01;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_wa[k] = 8'h00; m_ra[k] = 8'h00;
      s1_v[k] = 1'b0;  s1_e[k] = 1'b0; s1_d[k] = 8'h00;
      o_v[k]  = 1'b0;  o_e[k]  = 1'b0; o_d[k]  = 8'h00;
    end
  endtask

  task automatic model_tick();
    logic [1:0] c;
    logic [7:0] pl, nd;
    logic       nv, ne, we;
    if (!rst_n) begin
      model_reset();
      return;
    end
    c  = din[9:8];
    pl = din[7:0];
    for (int k = 0; k < 3; k++) begin
      nv = rx_valid && c == 2'b11;
      ne = nv && int'(m_ra[k]) >= depth[k];
      nd = (nv && !ne) ? m_mem[k][m_ra[k]] : 8'h00;
      we = rx_valid && c == 2'b01 && int'(m_wa[k]) >= depth[k];
      if (lat[k] == 1) begin
        o_v[k] = nv;
        o_e[k] = ne | we;
        if (nv) o_d[k] = nd;
      end else begin
        o_v[k] = s1_v[k];
        o_e[k] = s1_e[k] | we;
        if (s1_v[k]) o_d[k] = s1_d[k];
        s1_v[k] = nv;
        s1_e[k] = ne;
        if (nv) s1_d[k] = nd;
      end
      if (rx_valid) begin
        case (c)
          2'b00: m_wa[k] = pl;
          2'b01: begin
            if (!we) m_mem[k][m_wa[k]] = pl;
            if (auto_inc) m_wa[k] = m_inc(m_wa[k], depth[k]);
          end
          2'b10: m_ra[k] = pl;
          default: if (auto_inc) m_ra[k] = m_inc(m_ra[k], depth[k]);
        endcase
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    #1;
    check_eq("mdl_d0", {d0_tx, d0_err, d0_dout}, {o_v[0], o_e[0], o_d[0]});
    check_eq("mdl_d1", {d1_tx, d1_err, d1_dout}, {o_v[1], o_e[1], o_d[1]});
    check_eq("mdl_d2", {d2_tx, d2_err, d2_dout}, {o_v[2], o_e[2], o_d[2]});
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] p, input logic ai);
    rx_valid = 1'b1;
    din      = {c, p};
    auto_inc = ai;
    cycle();
    rx_valid = 1'b0;
    auto_inc = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = '0;
    auto_inc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_d0", {d0_tx, d0_err, d0_dout}, 10'h000);
    check_eq("rst_d1", {d1_tx, d1_err, d1_dout}, 10'h000);
    check_eq("rst_d2", {d2_tx, d2_err, d2_dout}, 10'h000);
    rst_n = 1'b1;

    // Fill every location so later reads have known contents.
    send(2'b00, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) send(2'b01, 8'(i) ^ 8'h5A, 1'b1);

    // Basic write then read; d2 has one extra cycle of latency.
    send(2'b00, 8'h10, 1'b0);
    send(2'b01, 8'hA5, 1'b0);
    send(2'b10, 8'h10, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check_eq("s1_d0", {d0_tx, d0_err, d0_dout}, {2'b10, 8'hA5});
    check_eq("s4_d2_early", {31'd0, d2_tx}, 32'd0);
    cycle();
    check_eq("s1_d0_hold", {d0_tx, d0_err, d0_dout}, {2'b00, 8'hA5});
    check_eq("s4_d2", {d2_tx, d2_err, d2_dout}, {2'b10, 8'hA5});
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("s4_idle", {30'd0, d0_tx, d2_tx}, 32'd0);
    end

    // Burst across the top of the address space.
    send(2'b00, 8'hFE, 1'b0);
    send(2'b01, 8'h11, 1'b1);
    send(2'b01, 8'h22, 1'b1);
    send(2'b01, 8'h33, 1'b1);
    send(2'b10, 8'hFE, 1'b0);
    send(2'b11, 8'h00, 1'b1);
    check_eq("s2_b0", {d0_tx, d0_err, d0_dout}, {2'b10, 8'h11});
    send(2'b11, 8'h00, 1'b1);
    check_eq("s2_b1", {d0_tx, d0_err, d0_dout}, {2'b10, 8'h22});
    send(2'b11, 8'h00, 1'b1);
    check_eq("s2_b2", {d0_tx, d0_err, d0_dout}, {2'b10, 8'h33});
    cycle();
    check_eq("s2_hold", {d0_tx, d0_err, d0_dout}, {2'b00, 8'h33});
    check_eq("s2_d2_b2", {d2_tx, d2_err, d2_dout}, {2'b10, 8'h33});
    send(2'b10, 8'h00, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check_eq("s2_wrap", {d0_tx, d0_err, d0_dout}, {2'b10, 8'h33});

    // Depth 200: out-of-range write, aliasing, read and wrap.
    send(2'b00, 8'hC8, 1'b0);
    send(2'b01, 8'h55, 1'b0);
    check_eq("s3_werr", {30'd0, d1_tx, d1_err}, 32'd1);
    send(2'b10, 8'h48, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check_eq("s3_alias48", {d1_tx, d1_err, d1_dout}, {2'b10, 8'h12});
    send(2'b10, 8'h00, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check_eq("s3_alias00", {d1_tx, d1_err, d1_dout}, {2'b10, 8'h22});
    send(2'b10, 8'hC8, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check_eq("s3_rerr", {d1_tx, d1_err, d1_dout}, {2'b11, 8'h00});
    send(2'b00, 8'hC7, 1'b0);
    send(2'b01, 8'h77, 1'b1);
    check_eq("s3_wok", {30'd0, d1_tx, d1_err}, 32'd0);
    send(2'b01, 8'h88, 1'b0);
    send(2'b10, 8'hC7, 1'b0);
    send(2'b11, 8'h00, 1'b1);
    check_eq("s3_rc7", {d1_tx, d1_err, d1_dout}, {2'b10, 8'h77});
    send(2'b11, 8'h00, 1'b0);
    check_eq("s3_r00", {d1_tx, d1_err, d1_dout}, {2'b10, 8'h88});
    send(2'b10, 8'hD0, 1'b0);
    send(2'b11, 8'h00, 1'b1);
    check_eq("s3_oor_inc", {d1_tx, d1_err, d1_dout}, {2'b11, 8'h00});
    send(2'b11, 8'h00, 1'b0);
    check_eq("s3_after_oor", {d1_tx, d1_err, d1_dout}, {2'b10, 8'h88});

    // Asynchronous reset while d2 still has a read in flight.
    send(2'b10, 8'h10, 1'b0);
    rx_valid = 1'b1;
    din      = {2'b11, 8'h00};
    cycle();
    #2;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    #1;
    check_eq("s5_d0", {d0_tx, d0_err, d0_dout}, 10'h000);
    check_eq("s5_d2", {d2_tx, d2_err, d2_dout}, 10'h000);
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_eq("s5_no_tx", {31'd0, d2_tx}, 32'd0);
    end
    send(2'b11, 8'h00, 1'b0);
    check_eq("s5_rd0", {d0_tx, d0_err, d0_dout}, {2'b10, 8'h33});
    send(2'b10, 8'h10, 1'b0);
    send(2'b11, 8'h00, 1'b0);
    check_eq("s5_keep", {d0_tx, d0_err, d0_dout}, {2'b10, 8'hA5});

    // Random command stream against the model.
    for (int i = 0; i < 10000; i++) begin
      rx_valid = ($urandom_range(0, 3) != 0);
      din      = 10'($urandom);
      auto_inc = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
